// File: rtl/muldiv_pkg.sv
// Shared op codes, FSM state type and sign helpers for the HI/LO multiply/divide sequencer.
package muldiv_pkg;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FIX
    } state_t;

    function automatic logic sign32(input logic [31:0] v);
        return v[31];
    endfunction

    // abs(0x8000_0000) stays 0x8000_0000, which is the correct unsigned magnitude.
    function automatic logic [31:0] abs32(input logic [31:0] v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

    function automatic logic op_is_muldiv(input logic [2:0] op);
        return op <= OP_DIVU;
    endfunction

    function automatic logic op_is_div(input logic [2:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic op_is_signed(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// Sign conditioning around the unsigned multu/divu units: operand magnitudes and
// sign flags on the way in, conditional negation of the results on the way out.
module muldiv_signfix
    import muldiv_pkg::*;
(
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        is_signed,
    output logic [31:0] a_mag,
    output logic [31:0] b_mag,
    output logic        sgn_res,
    output logic        sgn_rem,
    input  logic [63:0] mul_z,
    input  logic [31:0] div_q,
    input  logic [31:0] div_r,
    input  logic        neg_res,
    input  logic        neg_rem,
    output logic [63:0] prod,
    output logic [31:0] quot,
    output logic [31:0] rem
);

    always_comb begin
        a_mag   = is_signed ? abs32(rs_val) : rs_val;
        b_mag   = is_signed ? abs32(rt_val) : rt_val;
        sgn_res = is_signed & (sign32(rs_val) ^ sign32(rt_val));
        sgn_rem = is_signed & sign32(rs_val);
    end

    always_comb begin
        prod = neg_res ? (~mul_z + 64'd1) : mul_z;
        quot = neg_res ? (~div_q + 32'd1) : div_q;
        rem  = neg_rem ? (~div_r + 32'd1) : div_r;
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// Sequencer for the iterative multu/divu units and owner of architectural HI/LO.
// Optional build macro MULDIV_ABORT_EN: flush aborts an in-flight operation.
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int MUL_LAT = 34,
    parameter int DIV_LAT = 34,
    parameter int CNT_W   = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        rd_hilo,
    input  logic        flush,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        stall,
    output logic        done,
    output logic        mul_we,
    output logic        div_we,
    output logic        unit_rst,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    output logic [31:0] div_a,
    output logic [31:0] div_b,
    input  logic [63:0] mul_z,
    input  logic [31:0] div_q,
    input  logic [31:0] div_r
);

    state_t           state, state_next;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] last_cnt;
    logic             run_div, div_zero, neg_res_q, neg_rem_q, rst_pend;
    logic [31:0]      zero_hi;

    logic             abort, start_ok, accept, launch_zero;
    logic [31:0]      a_mag, b_mag;
    logic             sgn_res, sgn_rem;
    logic [63:0]      prod;
    logic [31:0]      quot, rem;

`ifdef MULDIV_ABORT_EN
    assign abort = flush & (state != ST_IDLE);
`else
    logic unused_flush;
    assign unused_flush = flush;
    assign abort        = 1'b0;
`endif

    muldiv_signfix u_signfix (
        .rs_val    (rs_val),
        .rt_val    (rt_val),
        .is_signed (op_is_signed(op)),
        .a_mag     (a_mag),
        .b_mag     (b_mag),
        .sgn_res   (sgn_res),
        .sgn_rem   (sgn_rem),
        .mul_z     (mul_z),
        .div_q     (div_q),
        .div_r     (div_r),
        .neg_res   (neg_res_q),
        .neg_rem   (neg_rem_q),
        .prod      (prod),
        .quot      (quot),
        .rem       (rem)
    );

    // A held op is taken in the FIX cycle so decode loses no cycle after done.
    assign start_ok    = start & (op <= OP_MTLO);
    assign accept      = start_ok & ((state == ST_IDLE) | ((state == ST_FIX) & ~abort));
    assign launch_zero = op_is_div(op) & (rt_val == '0);
    assign last_cnt    = run_div ? CNT_W'(DIV_LAT - 1) : CNT_W'(MUL_LAT - 1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        busy       = (state != ST_IDLE);
        done       = (state == ST_FIX) & ~abort;
        mul_we     = (state == ST_RUN) & ~run_div;
        div_we     = (state == ST_RUN) & run_div;
        stall      = (state == ST_RUN) & (start_ok | rd_hilo);
        case (state)
            ST_IDLE: begin
                if (accept && op_is_muldiv(op))
                    state_next = launch_zero ? ST_FIX : ST_RUN;
            end
            ST_RUN: begin
                if (abort)                  state_next = ST_IDLE;
                else if (count == last_cnt) state_next = ST_FIX;
            end
            ST_FIX: begin
                if (accept && op_is_muldiv(op))
                    state_next = launch_zero ? ST_FIX : ST_RUN;
                else
                    state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi        <= '0;
            lo        <= '0;
            count     <= '0;
            mul_a     <= '0;
            mul_b     <= '0;
            div_a     <= '0;
            div_b     <= '0;
            run_div   <= 1'b0;
            div_zero  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            zero_hi   <= '0;
            unit_rst  <= 1'b0;
            rst_pend  <= 1'b1;
        end else begin
            unit_rst <= rst_pend | abort;
            rst_pend <= 1'b0;
            if (state == ST_RUN)
                count <= count + 1'b1;
            if (done) begin
                if (div_zero) begin
                    lo <= '1;
                    hi <= zero_hi;
                end else if (run_div) begin
                    lo <= quot;
                    hi <= rem;
                end else begin
                    {hi, lo} <= prod;
                end
            end
            // Placed after the result write so an MTHI/MTLO taken in FIX wins.
            if (accept) begin
                case (op)
                    OP_MTHI: hi <= rs_val;
                    OP_MTLO: lo <= rs_val;
                    OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                        count     <= '0;
                        run_div   <= op_is_div(op);
                        div_zero  <= launch_zero;
                        zero_hi   <= rs_val;
                        neg_res_q <= sgn_res;
                        neg_rem_q <= sgn_rem;
                        if (op_is_div(op)) begin
                            div_a <= a_mag;
                            div_b <= b_mag;
                        end else begin
                            mul_a <= a_mag;
                            mul_b <= b_mag;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
